board_writer: RTL
=================

Name: board_writer

Overview:
- Maintains the Connect Four board state: the per-cell occupancy and owner registers.
- Accepts column-drop requests, scans each requested column upward from the bottom until it finds the lowest empty cell, and writes the current player's piece there.
- Toggles the current player after every successful drop.
- Acts as the writer side of the board bus; the horizontal, vertical and diagonal win checkers read the board from this block.

Parameters:
- COLS, 7, board columns.
- ROWS, 6, board rows.
- COL_W, 3, width of a column index; must satisfy 2^COL_W > COLS - 1.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- new_game  in  1  synchronous clear of the board; player returns to 1.
- drop_req  in  1  request to drop a piece; sampled in IDLE only.
- drop_col  in  COL_W  target column, 0 = leftmost; sampled with drop_req.
- win_in  in  1  OR of all win-checker wongame outputs; when high, the game is locked.
- board_player  out  ROWS*COLS  owner bit per cell, 1 = player 1.
- board_onoff  out  ROWS*COLS  occupancy bit per cell.
- current_player  out  1  player whose turn it is.
- busy  out  1  high when the FSM is not in IDLE.
- drop_ack  out  1  one-cycle pulse when a piece has been written.
- drop_err  out  1  one-cycle pulse when a request is rejected.
- last_row  out  3  row of the last written piece, 0 = bottom.
- last_col  out  COL_W  column of the last written piece.
- board_full  out  1  high when every cell's onoff bit is 1.

Behaviour:
- Cell index = row*COLS + col, with row 0 at the bottom. Each row therefore forms a contiguous COLS-bit slice, which is the format the win checkers consume.
- Reset (resetn low at an edge):
  - board_player = 0, board_onoff = 0, current_player = 1.
  - busy = 0, drop_ack = 0, drop_err = 0, last_row = 0, last_col = 0.
  - FSM goes to IDLE.
  - Reset is honoured in any state and abandons any scan in progress; no partial write occurs.
- new_game: same effect as reset. Ignored while resetn is low. It has priority over every FSM action in the same cycle.
- FSM states:
  - IDLE
    - drop_req=1, drop_col >= COLS, or win_in=1 → ERR.
    - drop_req=1 otherwise → latch the column, row counter = 0, go to SCAN.
  - SCAN
    - onoff[row][col]=0 → WRITE.
    - onoff[row][col]=1 and row = ROWS-1 → ERR (column full).
    - Otherwise → row+1, stay in SCAN.
  - WRITE
    - Set onoff[row][col]=1 and player[row][col]=current_player.
    - Toggle current_player.
    - Load last_row and last_col.
    - drop_ack=1 for one cycle; go to IDLE.
  - ERR
    - drop_err=1 for one cycle; go to IDLE.
    - Board and player are unchanged.
- Latency, with acceptance at edge E0 and landing row r:
  - Write and drop_ack rise at edge E0+r+2.
  - Full column: drop_err rises at E0+ROWS+1.
  - Invalid column or locked game: drop_err rises at E0+1.
- drop_req while busy is ignored (not queued). The requester must wait for drop_ack or drop_err.
- drop_req held high across several IDLE cycles is accepted again on each IDLE visit. The requester must deassert drop_req after receiving ack or err.
- board_full is combinational from board_onoff. A drop into a full board errors by the full-column path.
- win_in rising mid-scan does not abort the drop in progress; the lock applies only to subsequent requests.

Optional Feature:
- Macro: BOARD_UNDO_EN.
- When defined:
  - Adds input undo_req (1 bit).
  - In IDLE, undo_req has priority over drop_req.
  - If a valid last move exists: clear onoff and player at (last_row, last_col), toggle current_player back, pulse drop_ack, and invalidate the last move. Only one level of undo is supported.
  - If no valid last move exists: pulse drop_err.
  - Undo is permitted while win_in=1.
  - Reset and new_game invalidate the last move.
- When undefined: there is no undo_req port and no undo logic.

Test Plan:
- Reset, then drop_req with col=3 at E0 → drop_ack at E0+2; onoff bit 3 = 1, player bit 3 = 1; current_player = 0; last_row = 0, last_col = 3.
- Six drops into col 0 → rows 0..5 fill with alternating owners 1,0,1,0,1,0; the seventh drop → drop_err at E0+7 and the board is unchanged.
- drop_col = 7 → drop_err at E0+1; busy high for exactly one cycle.
- win_in = 1, then drop_req col=2 → drop_err, no write. Then new_game → board = 0 and current_player = 1.
- Assert resetn low during a SCAN into col 4 (row 3) → all outputs return to reset values and no bit is written in col 4.
- With BOARD_UNDO_EN: drop col 5, then undo_req → onoff and player return to all zeros, current_player = 1. A second undo_req → drop_err.

Source files
------------

// File: rtl/board_writer.sv
// -----------------------------------------------------------------------------
// board_writer
//
// Purpose:
//   Owns the Connect Four board registers (occupancy + owner per cell) and is
//   the only writer of them. A column drop is scanned upward from row 0 until
//   the first empty cell is found, then the current player's piece is written
//   there and the turn passes to the other player. The win checkers read
//   board_onoff / board_player directly.
//
//   Cell index = row*COLS + col, row 0 at the bottom, so every row is a
//   contiguous COLS-bit slice of the board vectors.
//
// Optional feature:
//   BOARD_UNDO_EN - adds undo_req and a one-level undo of the last move.
//
// Ports:
//   clk            in   rising-edge clock
//   resetn         in   synchronous active-low reset
//   new_game       in   synchronous board clear (same effect as reset)
//   drop_req       in   drop request, sampled in IDLE only
//   drop_col       in   target column, 0 = leftmost
//   win_in         in   game locked; new drops are rejected while high
//   undo_req       in   (BOARD_UNDO_EN only) undo the last move
//   board_player   out  owner bit per cell, 1 = player 1
//   board_onoff    out  occupancy bit per cell
//   current_player out  player whose turn it is
//   busy           out  FSM not in IDLE
//   drop_ack       out  one-cycle pulse: piece written (or undo done)
//   drop_err       out  one-cycle pulse: request rejected
//   last_row       out  row of the last written piece
//   last_col       out  column of the last written piece
//   board_full     out  every cell occupied
//   dbg_state      out  current FSM state encoding
//
// Handshake: the requester raises drop_req (or undo_req) and keeps the
// request stable until the matching drop_ack or drop_err pulse, then drops it.
// Requests seen while busy are ignored, never queued; a request still high on
// a later IDLE cycle is taken as a new request.
// -----------------------------------------------------------------------------
module board_writer #(
  parameter int COLS  = 7,
  parameter int ROWS  = 6,
  parameter int COL_W = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   new_game,
  input  logic                   drop_req,
  input  logic [COL_W-1:0]       drop_col,
  input  logic                   win_in,
`ifdef BOARD_UNDO_EN
  input  logic                   undo_req,
`endif
  output logic [ROWS*COLS-1:0]   board_player,
  output logic [ROWS*COLS-1:0]   board_onoff,
  output logic                   current_player,
  output logic                   busy,
  output logic                   drop_ack,
  output logic                   drop_err,
  output logic [2:0]             last_row,
  output logic [COL_W-1:0]       last_col,
  output logic                   board_full,
  output logic [2:0]             dbg_state
);

  localparam int IDX_W = $clog2(ROWS*COLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_WRITE = 3'd2,
    S_ERR   = 3'd3,
    S_UNDO  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ROWS*COLS-1:0] r_onoff;
  logic [ROWS*COLS-1:0] r_player;
  logic                 r_cur;
  logic [2:0]           r_row;
  logic [COL_W-1:0]     r_col;
  logic [2:0]           r_last_row;
  logic [COL_W-1:0]     r_last_col;
  logic                 r_ack;
  logic                 r_err;

  logic [IDX_W-1:0]     w_idx;
  logic                 w_cell_on;
  logic                 w_col_bad;
  logic                 w_top_row;
  logic                 w_accept;
  logic                 w_scan_adv;
  logic                 w_undo_go;

`ifdef BOARD_UNDO_EN
  logic                 r_last_valid;
  logic [IDX_W-1:0]     w_last_idx;
  assign w_last_idx = IDX_W'(r_last_row) * IDX_W'(COLS) + IDX_W'(r_last_col);
`endif

  // Cell currently addressed by the scan.
  assign w_idx     = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(r_col);
  assign w_cell_on = r_onoff[w_idx];
  assign w_top_row = (r_row == 3'(ROWS-1));
  // One extra bit so the compare still works when COLS == 2**COL_W.
  assign w_col_bad = ({1'b0, drop_col} >= (COL_W+1)'(COLS));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn || new_game) r_state <= S_IDLE;
    else                     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef BOARD_UNDO_EN
        // Undo wins over a simultaneous drop and is allowed in a locked game.
        if (undo_req) begin
          w_next = r_last_valid ? S_UNDO : S_ERR;
        end else
`endif
        if (drop_req) begin
          w_next = (w_col_bad || win_in) ? S_ERR : S_SCAN;
        end
      end
      S_SCAN: begin
        if (!w_cell_on)     w_next = S_WRITE;
        else if (w_top_row) w_next = S_ERR;
        else                w_next = S_SCAN;
      end
      S_WRITE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      S_UNDO:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (control strobes for the datapath)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (r_state != S_IDLE);
    w_accept   = 1'b0;
    w_scan_adv = 1'b0;
    w_undo_go  = 1'b0;
    if (r_state == S_IDLE && w_next == S_SCAN) w_accept = 1'b1;
    if (r_state == S_SCAN && w_cell_on && !w_top_row) w_scan_adv = 1'b1;
    if (r_state == S_UNDO) w_undo_go = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: board, turn, last move and response pulses.
  // Acks/errs are registered on leaving WRITE/ERR/UNDO, so they appear in
  // the first IDLE cycle after the action.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      r_onoff    <= '0;
      r_player   <= '0;
      r_cur      <= 1'b1;
      r_row      <= '0;
      r_col      <= '0;
      r_last_row <= '0;
      r_last_col <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
`ifdef BOARD_UNDO_EN
      r_last_valid <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_accept) begin
        r_col <= drop_col;
        r_row <= '0;
      end
      if (w_scan_adv) r_row <= r_row + 3'd1;
      if (r_state == S_WRITE) begin
        r_onoff[w_idx]  <= 1'b1;
        r_player[w_idx] <= r_cur;
        r_cur           <= ~r_cur;
        r_last_row      <= r_row;
        r_last_col      <= r_col;
        r_ack           <= 1'b1;
`ifdef BOARD_UNDO_EN
        r_last_valid    <= 1'b1;
`endif
      end
      if (r_state == S_ERR) r_err <= 1'b1;
`ifdef BOARD_UNDO_EN
      if (w_undo_go) begin
        r_onoff[w_last_idx]  <= 1'b0;
        r_player[w_last_idx] <= 1'b0;
        r_cur                <= ~r_cur;
        r_ack                <= 1'b1;
        r_last_valid         <= 1'b0;
      end
`endif
    end
  end

`ifndef BOARD_UNDO_EN
  // UNDO is unreachable in this build; the strobe exists only for symmetry.
  logic w_unused;
  assign w_unused = w_undo_go;
`endif

  assign board_onoff    = r_onoff;
  assign board_player   = r_player;
  assign current_player = r_cur;
  assign drop_ack       = r_ack;
  assign drop_err       = r_err;
  assign last_row       = r_last_row;
  assign last_col       = r_last_col;
  assign board_full     = &r_onoff;
  assign dbg_state      = r_state;

endmodule
